score_keeper: RTL and testbench
===============================

# score_keeper

Sequential BCD score and high-score tracker for the Sequence Memory game, sitting directly upstream of the per-digit 7-segment decoders. It counts correctly repeated rounds, latches the best score at game over, and presents one 4-bit BCD nibble per HEX digit. It also provides a per-digit blank mask for leading-zero suppression and for blinking a new high score. Each nibble feeds one decoder unchanged. The top level uses the blank mask to force the corresponding HEX output to all-off (7'h7F).

## Interface
- NUM_DIGITS, 2: number of BCD digits (1..6)
- BLINK_DIV, 25_000_000: clock cycles per blink half-period (1 Hz blink at 50 MHz); must be >= 2
- clock  in  1  system clock, all state on rising edge
- resetn  in  1  reset, synchronous, active-low
- inc  in  1  one-cycle pulse: round completed, score +1
- clear  in  1  one-cycle pulse: new game, score to 0, clears new_high
- game_over  in  1  one-cycle pulse: compare score against high score and update
- show_high  in  1  level: 1 = display high score, 0 = display current score
- digits  out  4*NUM_DIGITS  BCD nibbles of the selected value; digit i at [4i+3:4i], digit 0 least significant
- blank  out  NUM_DIGITS  1 = the top level blanks HEX digit i
- new_high  out  1  set when the last game_over produced a strictly higher high score

## Operation
- State: score and high (NUM_DIGITS BCD digits each), new_high, blink counter, blink phase.
- inc: score increments with decimal carry (9→0, carry to the next digit). At all-9s the score saturates and stays at all-9s; no wrap.
- clear: score ← 0, new_high ← 0. high is retained; only resetn clears it.
- game_over: if score > high, then high ← score and new_high ← 1. Otherwise nothing changes. The comparison is a plain unsigned compare of the concatenated nibbles, which is valid for BCD.
- Priority within one cycle:
  - clear beats everything. inc and game_over are ignored in that cycle.
  - game_over beats inc. The comparison uses the registered score, and that cycle's inc is dropped.
- Display value: high if show_high = 1, else score. digits always carries the selected value, including blanked positions.
- Leading-zero suppression: digit i (i ≥ 1) is blanked if it and all higher digits are 0. Digit 0 is never suppressed.
- Blink:
  - While new_high = 0, the counter is held at 0 and phase = on.
  - While new_high = 1, the counter counts 0..BLINK_DIV-1. At the wrap it returns to 0 and phase toggles.
  - When phase = off, blank is all ones, independent of show_high.
- Inputs must be valid BCD. Non-BCD values cannot arise internally.

## Timing
- Reset values: score 0, high 0, new_high 0, counter 0, phase on. Therefore digits = 0 and blank = all ones except bit 0.
- resetn low overrides all inputs in that cycle, including mid-blink or mid-game.
- Latency: every input event sampled at edge N is visible on digits, blank and new_high after edge N.
- show_high is combinational into the output mux. No extra cycle is added beyond the registered state.
- Blink phase first toggles BLINK_DIV cycles after new_high rises.
- No handshake. Pulses longer than one cycle count once per cycle high.

## Structure
- Shared package: BCD_W = 4, BLANK_SEG = 7'h7F, digit-count limits.
- Sub-module bcd_digit_counter: one BCD digit with enable, clear, carry-in, carry-out and an all-9s indication. It is instantiated NUM_DIGITS times for score, with a saturation gate formed from the AND of all-9s.
- high register, comparator, blink divider and output mux live in score_keeper.

## Test plan
Every scenario uses NUM_DIGITS = 2 and BLINK_DIV = 4.
1. Reset: resetn low for 1 cycle → digits = 8'h00, blank = 2'b10, new_high = 0.
2. Counting: 9 inc pulses → digits = 8'h09, blank = 2'b10. One more inc → digits = 8'h10, blank = 2'b00.
3. Saturation: 105 inc pulses from 0 → digits = 8'h99 and stays there.
4. High score:
   - Score 12, then game_over → high = 8'h12, new_high = 1. With show_high = 1, digits = 8'h12.
   - Then clear, 7 incs, game_over → high stays 8'h12, new_high = 0.
5. Collisions:
   - Score 5 with clear and inc in the same cycle → score 8'h00.
   - Score 3 with inc and game_over in the same cycle → high 8'h03, score stays 8'h03.
6. Blink: after a new high, blank = 2'b11 during cycles 4–7 and 12–15 after new_high rises, and is normal otherwise. After clear, blank returns to the normal suppression pattern on the next cycle.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// Shared constants and types for the score/high-score BCD display path.
package score_keeper_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // Segment pattern the top level drives on a blanked HEX digit.
  localparam logic [6:0] BLANK_SEG = 7'h7F;

  // Supported digit-count range.
  localparam int MIN_DIGITS = 1;
  localparam int MAX_DIGITS = 6;

  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } phase_e;

  function automatic logic bcd_is_zero(input logic [BCD_W-1:0] d);
    return d == '0;
  endfunction

endpackage

// File: rtl/score_keeper_bcd_digit_counter.sv
// One BCD digit: increments on en & cin, wraps 9->0 with carry out.
module bcd_digit_counter
  import score_keeper_pkg::*;
(
  input  logic             clock,
  input  logic             resetn,
  input  logic             en,
  input  logic             clr,
  input  logic             cin,
  output logic [BCD_W-1:0] q,
  output logic             cout,
  output logic             nine
);

  assign nine = (q == BCD_MAX);
  assign cout = cin & nine;

  // Digit register; clear dominates counting.
  always_ff @(posedge clock) begin
    if (!resetn || clr)  q <= '0;
    else if (en && cin)  q <= nine ? '0 : q + 1'b1;
  end

endmodule

// File: rtl/score_keeper.sv
// BCD score / high-score tracker feeding per-digit 7-segment decoders.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        inc,
  input  logic                        clear,
  input  logic                        game_over,
  input  logic                        show_high,
  output logic [BCD_W*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]       blank,
  output logic                        new_high
);

  localparam int CNT_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [NUM_DIGITS-1:0][BCD_W-1:0] score, high, disp;
  logic [NUM_DIGITS-1:0]            nine;
  logic [NUM_DIGITS:0]              cy;
  logic                             sat, step;
  logic [CNT_W-1:0]                 cnt;
  phase_e                           phase;
  logic [NUM_DIGITS:1]              zhi;

  // With carry-in tied high the top carry equals the all-9s AND; both
  // are folded in so the gate reads as the digit flags it is built from.
  assign sat  = (&nine) & cy[NUM_DIGITS];
  // game_over wins over inc; the comparison sees the registered score.
  assign step = inc & ~game_over & ~sat;
  assign cy[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < NUM_DIGITS; i++) begin : g_dig
      bcd_digit_counter u_dig (
        .clock  (clock),
        .resetn (resetn),
        .en     (step),
        .clr    (clear),
        .cin    (cy[i]),
        .q      (score[i]),
        .cout   (cy[i+1]),
        .nine   (nine[i])
      );
    end
  endgenerate

  // High-score latch; clear drops the new-high flag but keeps the record.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      high     <= '0;
      new_high <= 1'b0;
    end else if (clear) begin
      new_high <= 1'b0;
    end else if (game_over && (score > high)) begin
      high     <= score;
      new_high <= 1'b1;
    end
  end

  // Blink divider; held idle (phase on) unless a new high is showing.
  always_ff @(posedge clock) begin
    if (!resetn || !new_high || clear) begin
      cnt   <= '0;
      phase <= PH_ON;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      phase <= (phase == PH_ON) ? PH_OFF : PH_ON;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  // Display select is combinational so show_high costs no cycle.
  always_comb begin
    disp = show_high ? high : score;
  end

  assign digits = disp;

  // zhi[i]: digit i and every digit above it are zero.
  generate
    for (i = NUM_DIGITS - 1; i >= 1; i--) begin : g_lz
      if (i == NUM_DIGITS - 1) begin : g_top
        assign zhi[i] = bcd_is_zero(disp[i]);
      end else begin : g_mid
        assign zhi[i] = bcd_is_zero(disp[i]) & zhi[i+1];
      end
    end
    for (i = 0; i < NUM_DIGITS; i++) begin : g_blank
      if (i == 0) begin : g_lsd
        assign blank[i] = (phase == PH_OFF);
      end else begin : g_hi
        assign blank[i] = (phase == PH_OFF) | zhi[i];
      end
    end
  endgenerate

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with a scoreboard of expected outputs.
module tb_score_keeper;

  logic       clock = 1'b0;
  logic       resetn, inc, clear, game_over, show_high;
  logic [7:0] digits;
  logic [1:0] blank;
  logic       new_high;

  int tests = 0;
  int fails = 0;
  int score_m = 0;

  typedef struct {
    string      tag;
    logic [7:0] d;
    logic [1:0] b;
    logic       nh;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  score_keeper #(.NUM_DIGITS(2), .BLINK_DIV(4)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .inc       (inc),
    .clear     (clear),
    .game_over (game_over),
    .show_high (show_high),
    .digits    (digits),
    .blank     (blank),
    .new_high  (new_high)
  );

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [1:0] lz(input int v);
    return (v < 10) ? 2'b10 : 2'b00;
  endfunction

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    tests++;
    assert (digits === e.d) else begin
      fails++;
      $error("FAIL %s digits: got %h expected %h", e.tag, digits, e.d);
    end
    tests++;
    assert (blank === e.b) else begin
      fails++;
      $error("FAIL %s blank: got %b expected %b", e.tag, blank, e.b);
    end
    tests++;
    assert (new_high === e.nh) else begin
      fails++;
      $error("FAIL %s new_high: got %b expected %b", e.tag, new_high, e.nh);
    end
  endtask

  // Drive one cycle of pulses, record the expected post-edge outputs.
  task automatic step(input logic i, input logic c, input logic g, input string tag,
                      input logic [7:0] d, input logic [1:0] b, input logic nh);
    inc = i; clear = c; game_over = g;
    sb.push_back('{tag, d, b, nh});
    @(posedge clock); #1;
    inc = 1'b0; clear = 1'b0; game_over = 1'b0;
    pop_check();
  endtask

  // show_high path is combinational: change it and check without a clock.
  task automatic peek(input logic sh, input string tag,
                      input logic [7:0] d, input logic [1:0] b, input logic nh);
    show_high = sh;
    sb.push_back('{tag, d, b, nh});
    #1;
    pop_check();
  endtask

  task automatic incs(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      if (score_m < 99) score_m++;
      step(1'b1, 1'b0, 1'b0, tag, to_bcd(score_m), lz(score_m), 1'b0);
    end
  endtask

  task automatic do_reset(input string tag);
    resetn = 1'b0;
    score_m = 0;
    // Pulses held high during reset must have no effect.
    step(1'b1, 1'b0, 1'b1, tag, 8'h00, 2'b10, 1'b0);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; inc = 1'b0; clear = 1'b0; game_over = 1'b0; show_high = 1'b0;
    #2;
    do_reset("reset");

    // Counting through the decade boundary and into saturation.
    incs(105, "count");
    step(1'b0, 1'b0, 1'b0, "sat_hold", 8'h99, 2'b00, 1'b0);
    peek(1'b1, "high_zero", 8'h00, 2'b10, 1'b0);
    peek(1'b0, "score_back", 8'h99, 2'b00, 1'b0);

    // New high score then blink pattern.
    do_reset("reset_sat");
    incs(12, "to12");
    step(1'b0, 1'b0, 1'b1, "go_new_high", 8'h12, 2'b00, 1'b1);
    for (int k = 1; k <= 13; k++)
      step(1'b0, 1'b0, 1'b0, "blink", 8'h12, ((k % 8) >= 4) ? 2'b11 : 2'b00, 1'b1);
    score_m = 0;
    step(1'b0, 1'b1, 1'b0, "clear_in_blink", 8'h00, 2'b10, 1'b0);
    peek(1'b1, "high_12", 8'h12, 2'b00, 1'b0);
    peek(1'b0, "score_0", 8'h00, 2'b10, 1'b0);

    // Lower score does not displace the record.
    incs(7, "to7");
    step(1'b0, 1'b0, 1'b1, "go_lower", 8'h07, 2'b10, 1'b0);
    peek(1'b1, "high_kept", 8'h12, 2'b00, 1'b0);
    peek(1'b0, "score_7", 8'h07, 2'b10, 1'b0);

    // Collisions.
    do_reset("reset_coll");
    peek(1'b1, "high_cleared", 8'h00, 2'b10, 1'b0);
    peek(1'b0, "score_cleared", 8'h00, 2'b10, 1'b0);
    incs(5, "to5");
    score_m = 0;
    step(1'b1, 1'b1, 1'b0, "clear_inc", 8'h00, 2'b10, 1'b0);
    incs(3, "to3");
    step(1'b1, 1'b0, 1'b1, "inc_go", 8'h03, 2'b10, 1'b1);
    peek(1'b1, "inc_go_high", 8'h03, 2'b10, 1'b1);
    peek(1'b0, "inc_go_score", 8'h03, 2'b10, 1'b1);
    step(1'b1, 1'b0, 1'b0, "to4", 8'h04, 2'b10, 1'b1);
    score_m = 0;
    step(1'b0, 1'b1, 1'b1, "clear_go", 8'h00, 2'b10, 1'b0);
    peek(1'b1, "clear_go_high", 8'h03, 2'b10, 1'b0);
    peek(1'b0, "clear_go_score", 8'h00, 2'b10, 1'b0);

    // Reset in the middle of a blink off-phase.
    incs(5, "to5b");
    step(1'b0, 1'b0, 1'b1, "go_5", 8'h05, 2'b10, 1'b1);
    for (int k = 1; k <= 4; k++)
      step(1'b0, 1'b0, 1'b0, "blink5", 8'h05, (k >= 4) ? 2'b11 : 2'b10, 1'b1);
    do_reset("reset_blink");
    step(1'b0, 1'b0, 1'b0, "post_reset", 8'h00, 2'b10, 1'b0);
    peek(1'b1, "post_reset_high", 8'h00, 2'b10, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
